acquire_readout_sequencer: RTL
==============================

Name: acquire_readout_sequencer

Overview:
- Single-clock controller that runs one acquisition/readout cycle of the reservoir sample memory per host `start` command.
- Pulses `acquire_signal` to the acquisition controller and waits out the write window.
- Then walks the RAM read address from 0 to NR_LINES-1, producing one read strobe per line and forwarding each returned byte to the USB TX interface with a valid/ready handshake.
- Sits between the USB command decoder and the acquisition controller; it is the sole owner of the RAM read port.

Parameters:
- LOG_NR_LINES, 10, width of the RAM address.
- NR_LINES, 1024, number of bytes read out per run (1..2^LOG_NR_LINES).
- ARM_CYCLES, 4, cycles `acquire_signal` is held high (must span ≥1 fast-clock edge downstream).
- ACQ_CYCLES, 1040, cycles waited after arming before readout starts (≥ write window + margin).
- RD_LATENCY, 2, cycles from `rd_strobe` to valid `send_byte`.

Ports:
- CLOCK_50, in, 1, system clock, 50 MHz.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle request to begin a run; ignored unless idle.
- abort, in, 1, cancel the current run.
- acquire_signal, out, 1, arm pulse to the acquisition controller.
- ram_rd_address, out, LOG_NR_LINES, RAM read address.
- rd_strobe, out, 1, one-cycle read enable (read-clock enable for the RAM output register).
- send_byte, in, 8, RAM read data, valid RD_LATENCY cycles after `rd_strobe`.
- tx_data, out, 8, byte to the USB TX path.
- tx_valid, out, 1, `tx_data` valid.
- tx_ready, in, 1, USB path accepts the byte when `tx_valid` and `tx_ready` are both high.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at run completion (not on abort).

Behaviour:
- Reset (sync): state=IDLE; `acquire_signal`=0, `ram_rd_address`=0, `rd_strobe`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0; all counters cleared. Reset overrides every other input, including mid-run.
- IDLE: on `start`=1 → ARM. The cycle counter is loaded with ARM_CYCLES-1.
- ARM: `acquire_signal`=1 for exactly ARM_CYCLES cycles, then → WAIT_ACQ with the counter loaded to ACQ_CYCLES-1.
- WAIT_ACQ: count down; at 0 → READ with address=0.
- READ: `rd_strobe`=1 for one cycle with the current `ram_rd_address` → LAT.
- LAT: wait RD_LATENCY-1 cycles.
  - On the cycle `send_byte` is valid, register it into `tx_data`, set `tx_valid`=1 → SEND.
  - First byte therefore appears RD_LATENCY+1 cycles after the READ cycle.
- SEND: hold `tx_data` and `tx_valid` stable until `tx_ready`=1.
  - On accept, `tx_valid` drops the next cycle.
  - If address==NR_LINES-1 → DONE; otherwise address+1 → READ.
- Throughput: one byte per RD_LATENCY+2 cycles when `tx_ready` is held high.
- DONE: `done`=1 for one cycle, address returns to 0 → IDLE.
- Address arithmetic: unsigned, LOG_NR_LINES bits. Address never exceeds NR_LINES-1; no wrap occurs within a run.
- `start` while `busy`=1: ignored, no queueing.
- `abort`=1 in any non-IDLE state: next state is IDLE.
  - `acquire_signal`, `tx_valid`, `rd_strobe` and `busy` deassert the next cycle; no `done` pulse.
  - A byte presented in SEND is dropped even if `tx_ready` is high in the same cycle.
- `abort` and `start` together in IDLE: `abort` wins and the state remains IDLE.
- `tx_ready` high while `tx_valid`=0: no effect.
- `busy` is registered and equals (state != IDLE).

Optional Feature:
- Macro READOUT_CHECKSUM_EN.
- Defined: an 8-bit running sum (mod 256) of all accepted bytes is kept, cleared on entry to READ for address 0. After the last data byte is accepted, a CKSUM state presents the sum on `tx_data` with the same valid/ready handshake, then → DONE. Total bytes per run = NR_LINES+1.
- Undefined: no CKSUM state; exactly NR_LINES bytes per run.

Test Plan:
- Basic run: reset, NR_LINES=4, RAM model returns address XOR 0xA5, `tx_ready`=1 → `acquire_signal` high for exactly 4 cycles; first `rd_strobe` 1040 cycles after ARM ends; bytes 0xA5,0xA4,0xA7,0xA6 emitted; `done` pulses once; `busy` returns to 0.
- Backpressure: `tx_ready` low for 7 cycles on the 2nd byte → `tx_data` and `tx_valid` stable throughout; no extra `rd_strobe`; byte order unchanged.
- Abort mid-readout: `abort` asserted in SEND at address 2 → next cycle state is IDLE, `tx_valid`=0, `busy`=0, no `done`; the following `start` runs a full sequence from address 0.
- Ignored start: `start` pulsed during WAIT_ACQ and during SEND → no restart, exactly NR_LINES bytes delivered, a single `done`.
- Sync reset mid-run: `reset` asserted during ARM → the same cycle edge clears everything; `acquire_signal`=0 next cycle; outputs match reset values.
- Checksum (READOUT_CHECKSUM_EN): 4 bytes 0x10,0x20,0x30,0xF0 → 5th byte 0x50; `done` follows acceptance of the checksum byte.

Source files
------------

// File: rtl/acquire_readout_sequencer.sv
// Acquisition/readout sequencer: arms the acquisition controller, waits out the write window,
// then streams NR_LINES bytes from the sample RAM to the USB TX path. Option: READOUT_CHECKSUM_EN.
module acquire_readout_sequencer #(
  parameter int unsigned LOG_NR_LINES = 10,
  parameter int unsigned NR_LINES     = 1024,
  parameter int unsigned ARM_CYCLES   = 4,
  parameter int unsigned ACQ_CYCLES   = 1040,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic                    acquire_signal,
  output logic [LOG_NR_LINES-1:0] ram_rd_address,
  output logic                    rd_strobe,
  input  logic [7:0]              send_byte,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CNT_MAX0 = (ACQ_CYCLES > ARM_CYCLES) ? ACQ_CYCLES : ARM_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > RD_LATENCY) ? CNT_MAX0 : RD_LATENCY;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [LOG_NR_LINES-1:0] LAST_ADDR = LOG_NR_LINES'(NR_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_ACQ, S_READ, S_LAT, S_SEND, S_CKSUM, S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [LOG_NR_LINES-1:0] addr_n;
  logic [7:0]              tx_data_n;
  logic                    tx_valid_n;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]              sum, sum_n;
`endif

  // Next-state and next-register values; abort overrides every state.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = ram_rd_address;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
`ifdef READOUT_CHECKSUM_EN
    sum_n      = sum;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ARM;
          cnt_n   = CNT_W'(ARM_CYCLES - 1);
        end
      end
      S_ARM: begin
        if (cnt == '0) begin
          state_n = S_WAIT_ACQ;
          cnt_n   = CNT_W'(ACQ_CYCLES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WAIT_ACQ: begin
        if (cnt == '0) begin
          state_n = S_READ;
          addr_n  = '0;
`ifdef READOUT_CHECKSUM_EN
          sum_n   = '0;
`endif
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_READ: begin
        state_n = S_LAT;
        cnt_n   = CNT_W'(RD_LATENCY - 1);
      end
      S_LAT: begin
        if (cnt == '0) begin
          state_n    = S_SEND;
          tx_data_n  = send_byte;
          tx_valid_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
`ifdef READOUT_CHECKSUM_EN
          sum_n      = sum + tx_data;
`endif
          if (ram_rd_address == LAST_ADDR) begin
`ifdef READOUT_CHECKSUM_EN
            // Checksum byte follows the last data byte with no idle gap.
            state_n    = S_CKSUM;
            tx_data_n  = sum + tx_data;
            tx_valid_n = 1'b1;
`else
            state_n    = S_DONE;
`endif
          end else begin
            addr_n  = ram_rd_address + LOG_NR_LINES'(1);
            state_n = S_READ;
          end
        end
      end
`ifdef READOUT_CHECKSUM_EN
      S_CKSUM: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_n = S_IDLE;
        addr_n  = '0;
      end
      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      addr_n     = '0;
      tx_valid_n = 1'b0;
    end
  end

  // State and output registers; strobes are decoded from the next state so they align with it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      ram_rd_address <= '0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      acquire_signal <= 1'b0;
      rd_strobe      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      ram_rd_address <= addr_n;
      tx_data        <= tx_data_n;
      tx_valid       <= tx_valid_n;
      acquire_signal <= (state_n == S_ARM);
      rd_strobe      <= (state_n == S_READ);
      busy           <= (state_n != S_IDLE);
      done           <= (state_n == S_DONE);
`ifdef READOUT_CHECKSUM_EN
      sum            <= sum_n;
`endif
    end
  end

endmodule
